// File: rtl/sync_filter.sv
// Multi-channel input synchronizer with a consecutive-sample glitch filter and rise/fall pulses.
// Optional macro SYNC_FILTER_STICKY_EN adds per-channel sticky event flags with clr.
module sync_filter #(
   parameter int              WIDTH         = 4,
   parameter int              STAGES        = 2,
   parameter int              FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] RST_VAL      = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] in_async,
`ifdef SYNC_FILTER_STICKY_EN
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] sticky,
`endif
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam int             CW   = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0]  LAST = CW'(FILTER_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] s;
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [CW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_d;

   // Plain flop chain: nothing may sit between stages or metastability gets no time to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) sync_q[k] <= RST_VAL;
      end else begin
         sync_q[0] <= in_async;
         for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[STAGES-1];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no branch can infer a latch.
      out_d  = out;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (en && (s[i] != out[i])) begin
            if (cnt_q[i] == LAST) begin
               out_d[i]  = s[i];
               rise_d[i] = s[i];
               fall_d[i] = ~s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
         out     <= RST_VAL;
         rise    <= '0;
         fall    <= '0;
         changed <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
         out     <= out_d;
         rise    <= rise_d;
         fall    <= fall_d;
         changed <= |(rise_d | fall_d);
      end
   end

`ifdef SYNC_FILTER_STICKY_EN
   // A pulse in the same cycle as clr keeps the flag set, so no event is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sticky <= '0;
      else     sticky <= (sticky & ~clr) | rise | fall;
   end
`endif

endmodule
